// File: rtl/cache_bus_arbiter_pkg.sv
// Shared types and constants for the I$/D$ line-burst bus arbiter.
package cache_bus_arbiter_pkg;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        ACK   = 2'd3
    } arb_state_e;

    localparam int LINELEN_DEF  = 512;
    localparam int AHBW_DEF     = 64;
    localparam int BEATSPERLINE = LINELEN_DEF / AHBW_DEF;

endpackage

// File: rtl/cache_bus_beat_counter.sv
// Beat counter for one line burst: counts accepted beats, wraps after the
// last beat of the line and flags that last beat combinationally.
module cache_bus_beat_counter import cache_bus_arbiter_pkg::*; #(
    parameter int LOGBWPL = 3,
    parameter int BEATS   = BEATSPERLINE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en_i,
    input  logic               clr_i,
    output logic [LOGBWPL-1:0] cnt_o,
    output logic               last_o
);

    localparam logic [LOGBWPL-1:0] LAST = LOGBWPL'(BEATS - 1);

    logic [LOGBWPL-1:0] cnt_q, cnt_d;

    assign last_o = en_i & (cnt_q == LAST);
    assign cnt_o  = cnt_q;

    // Next count: clear on state entry, otherwise advance/wrap on each beat
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = last_o ? '0 : cnt_q + LOGBWPL'(1);
    end

    // Count register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/cache_bus_arbiter.sv
// Arbitrates the shared line-burst bus engine between I$ (0) and D$ (1),
// sequences writeback/fetch bursts and returns a one-cycle Ack.
// Optional: define CACHE_ARB_ROUNDROBIN_EN for round-robin arbitration on
// simultaneous requests (otherwise fixed priority from D_PRIORITY).
module cache_bus_arbiter import cache_bus_arbiter_pkg::*; #(
    parameter int PA_BITS    = 56,
    parameter int LINELEN    = 512,
    parameter int AHBW       = 64,
    parameter int LOGBWPL    = 3,
    parameter int D_PRIORITY = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         IBusRW,
    input  logic [PA_BITS-1:0] IBusAdr,
    output logic               IBusAck,
    input  logic [1:0]         DBusRW,
    input  logic [PA_BITS-1:0] DBusAdr,
    input  logic [PA_BITS-1:0] DWbAdr,
    output logic               DBusAck,
    input  logic               IFlushStage,
    input  logic               DFlushStage,
    output logic [LOGBWPL-1:0] BeatCount,
    output logic               SelBusBeat,
    output logic               GrantD,
    output logic               BusReq,
    output logic               BusWrite,
    output logic [PA_BITS-1:0] BusAdr,
    input  logic               BeatDone
);

    localparam int                 OFFBITS   = $clog2(LINELEN / 8);
    localparam logic [PA_BITS-1:0] LINE_MASK = ~PA_BITS'((1 << OFFBITS) - 1);

    arb_state_e         state_q, state_d;
    logic               grant_d_q, grant_d_d;
    logic [1:0]         rw_q, rw_d;
    logic [PA_BITS-1:0] fadr_q, fadr_d;
    logic [PA_BITS-1:0] wadr_q, wadr_d;

    logic req_i, req_d, win_d, grant;
    logic beat_en, beat_clr, last_beat;

    // I$ never writes; only the fetch bit matters
    logic unused_ibusrw0;
    assign unused_ibusrw0 = IBusRW[0];

    assign req_i = IBusRW[1] & ~IFlushStage;
    assign req_d = (|DBusRW) & ~DFlushStage;
    assign grant = (state_q == IDLE) & (req_i | req_d);

`ifdef CACHE_ARB_ROUNDROBIN_EN
    // rr_q remembers who was served last (1 = D$); the other side wins ties
    logic rr_q, rr_d;
    localparam int UNUSED_DPRI = D_PRIORITY;

    assign win_d = req_d & (~req_i | ~rr_q);
    assign rr_d  = (state_q == ACK) ? grant_d_q : rr_q;

    // Round-robin pointer, advanced once per completed transaction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rr_q <= 1'b0;
        else        rr_q <= rr_d;
    end
`else
    assign win_d = req_d & (~req_i | (D_PRIORITY != 0));
`endif

    assign beat_en  = BeatDone & ((state_q == WRITE) | (state_q == READ));
    assign beat_clr = (state_d != state_q);
    assign GrantD   = grant_d_q;

    cache_bus_beat_counter #(
        .LOGBWPL (LOGBWPL),
        .BEATS   (LINELEN / AHBW)
    ) u_beat_cnt (
        .clk    (clk),
        .reset  (reset),
        .en_i   (beat_en),
        .clr_i  (beat_clr),
        .cnt_o  (BeatCount),
        .last_o (last_beat)
    );

    // Capture the winner and its request at grant; later input changes are ignored
    always_comb begin
        grant_d_d = grant_d_q;
        rw_d      = rw_q;
        fadr_d    = fadr_q;
        wadr_d    = wadr_q;
        if (grant) begin
            grant_d_d = win_d;
            rw_d      = win_d ? DBusRW : 2'b10;
            fadr_d    = (win_d ? DBusAdr : IBusAdr) & LINE_MASK;
            wadr_d    = DWbAdr & LINE_MASK;
        end
    end

    // FSM next state and bus outputs
    always_comb begin
        state_d    = state_q;
        BusReq     = 1'b0;
        BusWrite   = 1'b0;
        SelBusBeat = 1'b0;
        BusAdr     = '0;
        IBusAck    = 1'b0;
        DBusAck    = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant) state_d = (win_d & DBusRW[0]) ? WRITE : READ;
            end
            WRITE: begin
                BusReq     = 1'b1;
                BusWrite   = 1'b1;
                SelBusBeat = 1'b1;
                BusAdr     = wadr_q;
                if (last_beat) state_d = rw_q[1] ? READ : ACK;
            end
            READ: begin
                BusReq = 1'b1;
                BusAdr = fadr_q;
                if (last_beat) state_d = ACK;
            end
            ACK: begin
                IBusAck = ~grant_d_q;
                DBusAck = grant_d_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and grant-time capture registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            grant_d_q <= 1'b0;
            rw_q      <= 2'b00;
            fadr_q    <= '0;
            wadr_q    <= '0;
        end else begin
            state_q   <= state_d;
            grant_d_q <= grant_d_d;
            rw_q      <= rw_d;
            fadr_q    <= fadr_d;
            wadr_q    <= wadr_d;
        end
    end

endmodule
